stream_capture_bram: RTL and testbench

Capture sink for 32-bit AXI-stream link data. It sits directly downstream of the BRAM pattern streamer, or on any received link, and writes a triggered window of stream beats into a block RAM through a native BRAM port. The processor reads the capture back over AXI BRAM. Arm, trigger mode and length come from the wrapper's parameter registers. Status goes back the same way.

---
 rtl/stream_capture_bram.sv | 173 +++++++++++++++++
 tb/tb_stream_capture_bram.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_capture_bram.sv
// Triggered capture of 32-bit stream beats into a block RAM via a native write port.
// Latency: a beat accepted in cycle N is written (EN/WE/ADDR/DIN registered) in cycle N+1.
// Backpressure: none; TREADY is !reset, beats outside the trigger cycle or CAPTURE are dropped.
module stream_capture_bram #(
    parameter int MEM_DEPTH = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fc_orbitSync,
    input  logic        cfg_arm,
    input  logic        cfg_abort,
    input  logic [1:0]  cfg_trig_mode,
    input  logic [3:0]  cfg_orbit_skip,
    input  logic [15:0] cfg_length,
    input  logic [31:0] s_axis_TDATA,
    input  logic        s_axis_TVALID,
    output logic        s_axis_TREADY,
    output logic        bram_CLK,
    output logic        bram_RST,
    output logic        bram_EN,
    output logic [3:0]  bram_WE,
    output logic [31:0] bram_ADDR,
    output logic [31:0] bram_DIN,
    output logic        busy,
    output logic        done,
    output logic [15:0] words_captured
);
    localparam int AW = $clog2(MEM_DEPTH);
    // One extra bit so the count and length can represent MEM_DEPTH itself.
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [3:0]      skip_q, skip_d;
    logic [3:0]      skip_cnt_q, skip_cnt_d;
    logic [CW-1:0]   len_q, len_d;
    logic [CW-1:0]   wc_q, wc_d;
    logic            en_q, en_d;
    logic [3:0]      we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     din_q, din_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            trig;
    logic            accept;
    logic [CW-1:0]   eff_len;

    // Next-state, trigger evaluation and write-port staging.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        skip_d     = skip_q;
        skip_cnt_d = skip_cnt_q;
        len_d      = len_q;
        wc_d       = wc_q;
        en_d       = 1'b0;
        we_d       = 4'h0;
        addr_d     = addr_q;
        din_d      = din_q;
        trig       = 1'b0;
        accept     = 1'b0;

        // Zero or oversize requests capture the whole RAM.
        if (cfg_length == 16'd0 || {16'd0, cfg_length} > 32'(MEM_DEPTH)) begin
            eff_len = CW'(MEM_DEPTH);
        end else begin
            eff_len = CW'(cfg_length);
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (cfg_arm) begin
                    state_d    = S_ARMED;
                    mode_d     = cfg_trig_mode;
                    skip_d     = cfg_orbit_skip;
                    len_d      = eff_len;
                    wc_d       = '0;
                    skip_cnt_d = '0;
                end
            end
            S_ARMED: begin
                case (mode_q)
                    2'd1: begin
                        if (fc_orbitSync) begin
                            if (skip_cnt_q == skip_q) begin
                                trig = 1'b1;
                            end else begin
                                skip_cnt_d = skip_cnt_q + 4'd1;
                            end
                        end
                    end
                    2'd2:    trig = s_axis_TVALID && (s_axis_TDATA != 32'd0);
                    default: trig = 1'b1;
                endcase
                if (trig) begin
                    state_d = S_CAPTURE;
                    accept  = s_axis_TVALID;
                end
            end
            S_CAPTURE: accept = s_axis_TVALID;
            default:   state_d = S_IDLE;
        endcase

        if (accept) begin
            en_d   = 1'b1;
            we_d   = 4'hF;
            addr_d = wc_q[AW-1:0];
            din_d  = s_axis_TDATA;
            wc_d   = wc_q + CW'(1);
            if (wc_d == len_q) begin
                state_d = S_DONE;
            end
        end

        // Abort overrides arm and suppresses this cycle's write; the count is kept.
        if (cfg_abort) begin
            state_d    = S_IDLE;
            en_d       = 1'b0;
            we_d       = 4'h0;
            addr_d     = addr_q;
            din_d      = din_q;
            wc_d       = wc_q;
            skip_cnt_d = skip_cnt_q;
        end

        busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE);
        done_d = (state_d == S_DONE);
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mode_q     <= 2'd0;
            skip_q     <= 4'd0;
            skip_cnt_q <= 4'd0;
            len_q      <= '0;
            wc_q       <= '0;
            en_q       <= 1'b0;
            we_q       <= 4'h0;
            addr_q     <= '0;
            din_q      <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            skip_q     <= skip_d;
            skip_cnt_q <= skip_cnt_d;
            len_q      <= len_d;
            wc_q       <= wc_d;
            en_q       <= en_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign s_axis_TREADY  = !reset;
    assign bram_CLK       = clk;
    assign bram_RST       = reset;
    assign bram_EN        = en_q;
    assign bram_WE        = we_q;
    assign bram_ADDR      = {{(30 - AW){1'b0}}, addr_q, 2'b00};
    assign bram_DIN       = din_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign words_captured = 16'(wc_q);
endmodule

// File: tb/tb_stream_capture_bram.sv
// Bench for stream_capture_bram: table-driven randomized runs checked against a
// window-selection model over the recorded stimulus, plus hand sequences for
// abort, mid-capture reset and arm corner cases.
module tb_stream_capture_bram;
    logic        clk = 1'b0;
    logic        reset;
    logic        fc_orbitSync;
    logic        cfg_arm;
    logic        cfg_abort;
    logic [1:0]  cfg_trig_mode;
    logic [3:0]  cfg_orbit_skip;
    logic [15:0] cfg_length;
    logic [31:0] s_axis_TDATA;
    logic        s_axis_TVALID;
    logic        s_axis_TREADY;
    logic        bram_CLK;
    logic        bram_RST;
    logic        bram_EN;
    logic [3:0]  bram_WE;
    logic [31:0] bram_ADDR;
    logic [31:0] bram_DIN;
    logic        busy;
    logic        done;
    logic [15:0] words_captured;

    always #5 clk = ~clk;

    stream_capture_bram #(.MEM_DEPTH(2048)) dut (
        .clk(clk), .reset(reset), .fc_orbitSync(fc_orbitSync),
        .cfg_arm(cfg_arm), .cfg_abort(cfg_abort), .cfg_trig_mode(cfg_trig_mode),
        .cfg_orbit_skip(cfg_orbit_skip), .cfg_length(cfg_length),
        .s_axis_TDATA(s_axis_TDATA), .s_axis_TVALID(s_axis_TVALID),
        .s_axis_TREADY(s_axis_TREADY), .bram_CLK(bram_CLK), .bram_RST(bram_RST),
        .bram_EN(bram_EN), .bram_WE(bram_WE), .bram_ADDR(bram_ADDR),
        .bram_DIN(bram_DIN), .busy(busy), .done(done),
        .words_captured(words_captured)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [3:0]  skip;
        logic [15:0] len;
        int          pct;       // 100 = always valid, 0 = valid on odd cycles
        int          period;    // orbit sync period, 0 = random syncs
        int          exp_words;
    } vec_t;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int s0       = 0;

    logic [31:0] mem [0:2047];
    int          wl_cyc[$];
    logic [31:0] wl_addr[$];
    logic [31:0] wl_dat[$];
    logic [3:0]  wl_we[$];
    bit          q_v[$];
    bit          q_s[$];
    bit          q_ab[$];
    logic [31:0] q_d[$];
    int          exp_cyc[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_dat[$];
    int          exp_cnt;
    bit          exp_done;

    // RAM model and write log, sampled at the committing edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bram_EN === 1'b1) begin
            wl_cyc.push_back(cyc);
            wl_addr.push_back(bram_ADDR);
            wl_dat.push_back(bram_DIN);
            wl_we.push_back(bram_WE);
            if (bram_WE == 4'hF) mem[bram_ADDR[12:2]] <= bram_DIN;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] d, input bit sy, input bit arm, input bit ab);
        s_axis_TVALID = v;
        s_axis_TDATA  = d;
        fc_orbitSync  = sy;
        cfg_arm       = arm;
        cfg_abort     = ab;
        q_v.push_back(v);
        q_d.push_back(d);
        q_s.push_back(sy);
        q_ab.push_back(ab);
        @(posedge clk);
        #1;
        cfg_arm   = 1'b0;
        cfg_abort = 1'b0;
    endtask

    task automatic begin_run();
        q_v.delete(); q_d.delete(); q_s.delete(); q_ab.delete();
        wl_cyc.delete(); wl_addr.delete(); wl_dat.delete(); wl_we.delete();
        s0 = cyc;
    endtask

    // Picks the capture window straight from the recorded stimulus: find the
    // trigger cycle by the mode rule, then take the first L valid beats from it
    // up to (not including) any abort.
    task automatic model(input int mode, input int skip, input int len);
        int n, L, trig, ab, syncs;
        n = q_v.size();
        L = (len == 0 || len > 2048) ? 2048 : len;
        trig = -1;
        ab = n;
        syncs = 0;
        for (int i = 1; i < n; i++) if (q_ab[i]) begin ab = i; break; end
        if (mode == 1) begin
            for (int i = 1; i < n; i++) begin
                if (q_s[i]) begin
                    syncs++;
                    if (syncs == skip + 1) begin trig = i; break; end
                end
            end
        end else if (mode == 2) begin
            for (int i = 1; i < n; i++) if (q_v[i] && q_d[i] != 32'd0) begin trig = i; break; end
        end else begin
            trig = 1;
        end
        exp_cyc.delete(); exp_addr.delete(); exp_dat.delete();
        exp_cnt = 0;
        if (trig >= 1 && trig < ab) begin
            for (int i = trig; i < ab && exp_cnt < L; i++) begin
                if (q_v[i]) begin
                    exp_cyc.push_back(s0 + i + 1);
                    exp_addr.push_back(32'(exp_cnt * 4));
                    exp_dat.push_back(q_d[i]);
                    exp_cnt++;
                end
            end
        end
        exp_done = (exp_cnt == L);
    endtask

    task automatic compare(input string tag);
        int n, e0;
        chk({tag, "_nwrites"}, wl_cyc.size(), exp_cyc.size());
        n = (wl_cyc.size() < exp_cyc.size()) ? wl_cyc.size() : exp_cyc.size();
        for (int i = 0; i < n; i++) begin
            e0 = n_err;
            chk({tag, "_wr_cycle"}, wl_cyc[i], exp_cyc[i]);
            chk({tag, "_wr_addr"}, wl_addr[i], exp_addr[i]);
            chk({tag, "_wr_data"}, wl_dat[i], exp_dat[i]);
            chk({tag, "_wr_we"}, wl_we[i], 4'hF);
            if (n_err != e0) break;
        end
        for (int k = 0; k < exp_cnt; k++) begin
            e0 = n_err;
            chk({tag, "_ram_word"}, mem[exp_addr[k][12:2]], exp_dat[k]);
            if (n_err != e0) break;
        end
        chk({tag, "_words_captured"}, words_captured, exp_cnt);
        chk({tag, "_done"}, done, exp_done);
    endtask

    task automatic gen(input vec_t t, input int i, output bit v, output logic [31:0] d, output bit sy);
        if (t.pct >= 100) v = 1'b1;
        else if (t.pct == 0) v = (i % 2 == 1);
        else v = ($urandom_range(99) < t.pct);
        sy = (t.period > 0) ? (i > 0 && i % t.period == 0) : ($urandom_range(49) == 0);
        if (t.mode == 2'd2) d = (i < 9) ? 32'd0 : (i == 9) ? 32'hABCD0001 : $urandom;
        else if (t.mode == 2'd1) d = 32'h5000_0000 + 32'(i);
        else d = $urandom;
    endtask

    task automatic run_vec(input vec_t t, input string tag);
        bit v, sy;
        logic [31:0] d;
        int i, budget;
        cfg_trig_mode  = t.mode;
        cfg_orbit_skip = t.skip;
        cfg_length     = t.len;
        begin_run();
        budget = t.exp_words * 4 + 2000;
        gen(t, 0, v, d, sy);
        drive(v, d, sy, 1'b1, 1'b0);
        chk({tag, "_busy_after_arm"}, busy, 1);
        i = 1;
        while (done !== 1'b1 && i < budget) begin
            gen(t, i, v, d, sy);
            drive(v, d, sy, 1'b0, 1'b0);
            i++;
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        model(int'(t.mode), int'(t.skip), int'(t.len));
        compare(tag);
        chk({tag, "_words_tbl"}, words_captured, t.exp_words);
        chk({tag, "_busy_end"}, busy, 0);
        if (t.exp_words == 2048 && wl_addr.size() > 0)
            chk({tag, "_last_addr"}, wl_addr[wl_addr.size() - 1], 32'h1FFC);
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{2'd0, 4'd0,  16'd4,    100, 0,   4};
        tbl[1]  = '{2'd0, 4'd0,  16'd37,   60,  0,   37};
        tbl[2]  = '{2'd1, 4'd2,  16'd8,    100, 100, 8};
        tbl[3]  = '{2'd1, 4'd0,  16'd5,    50,  0,   5};
        tbl[4]  = '{2'd2, 4'd0,  16'd3,    0,   0,   3};
        tbl[5]  = '{2'd3, 4'd0,  16'd10,   70,  0,   10};
        tbl[6]  = '{2'd0, 4'd0,  16'd0,    100, 0,   2048};
        tbl[7]  = '{2'd2, 4'd0,  16'd5000, 90,  0,   2048};
        tbl[8]  = '{2'd1, 4'd15, 16'd2,    80,  20,  2};
        tbl[9]  = '{2'd0, 4'd0,  16'd1,    100, 0,   1};
        tbl[10] = '{2'd2, 4'd0,  16'd6,    40,  0,   6};

        reset = 1'b1; fc_orbitSync = 1'b0; cfg_arm = 1'b0; cfg_abort = 1'b0;
        cfg_trig_mode = 2'd0; cfg_orbit_skip = 4'd0; cfg_length = 16'd4;
        s_axis_TDATA = 32'd0; s_axis_TVALID = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tready", s_axis_TREADY, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_words", words_captured, 0);
        chk("rst_en", bram_EN, 0);
        chk("rst_addr", bram_ADDR, 0);
        reset = 1'b0;
        #1;
        chk("tready_run", s_axis_TREADY, 1);

        // Mode 0, L=4, data 0x10..0x13 right after the arm cycle
        cfg_trig_mode = 2'd0; cfg_length = 16'd4;
        begin_run();
        drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) drive(1'b1, 32'h10 + 32'(k), 1'b0, 1'b0, 1'b0);
        chk("m0l4_done_on_4th", done, 1);
        chk("m0l4_en_on_4th", bram_EN, 1);
        chk("m0l4_din_on_4th", bram_DIN, 32'h13);
        chk("m0l4_busy_on_4th", busy, 0);
        drive(1'b1, 32'h99, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        model(0, 0, 4);
        compare("m0l4");

        // Table of randomized runs
        for (int t = 0; t < 11; t++) run_vec(tbl[t], $sformatf("vec%0d", t));

        // Abort after 7 words, then re-arm
        cfg_trig_mode = 2'd0; cfg_length = 16'd100;
        begin_run();
        drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) drive(1'b1, 32'hA0 + 32'(k), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) drive(1'b1, 32'hBEEF, 1'b0, 1'b0, 1'b0);
        model(0, 0, 100);
        compare("abort7");
        chk("abort7_words", words_captured, 7);
        chk("abort7_busy", busy, 0);
        run_vec(tbl[1], "rearm_after_abort");

        // Reset asserted mid-capture
        cfg_trig_mode = 2'd0; cfg_length = 16'd50;
        begin_run();
        drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) drive(1'b1, 32'hC0 + 32'(k), 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_tready", s_axis_TREADY, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_words", words_captured, 0);
        chk("midrst_en", bram_EN, 0);
        chk("midrst_we", bram_WE, 0);
        chk("midrst_addr", bram_ADDR, 0);
        chk("midrst_din", bram_DIN, 0);
        for (int k = 0; k < 3; k++) drive(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
        chk("midrst_nwrites", wl_cyc.size(), 10);
        run_vec(tbl[0], "rearm_after_reset");

        // Arm during CAPTURE is ignored; arm+abort in DONE gives IDLE
        cfg_trig_mode = 2'd0; cfg_length = 16'd20;
        begin_run();
        drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k < 100 && done !== 1'b1; k++) drive(1'b1, $urandom, 1'b0, k == 5, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        model(0, 0, 20);
        compare("arm_in_cap");
        drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        chk("arm_abort_done", done, 0);
        chk("arm_abort_busy", busy, 0);
        chk("arm_abort_words", words_captured, 20);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("arm_abort_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
